rv_run_ctrl: RTL

//  Run controller for the single-cycle RV core (rv_pl). Owns port B of the instruction and data BRAMs:
//  a host (PS/loader) preloads/inspects memory while the core is held in reset, then the block releases
//  the core, counts cycles, detects halt or timeout, re-holds the core and hands memory back to the host.

---
 rtl/rv_run_ctrl_pkg.sv | 13 +
 rtl/rv_run_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rv_run_ctrl_pkg.sv
// rtl/rv_run_ctrl_pkg.sv - shared state encoding and halt opcode for the run controller
package rv_run_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } run_state_t;

    // jal x0,0 : the core spins on itself once the program has finished
    localparam logic [31:0] HALT_OPCODE = 32'h0000_006F;

endpackage

// File: rtl/rv_run_ctrl.sv
// rtl/rv_run_ctrl.sv - run controller: host preload/inspect of core BRAMs, core release, halt/timeout detect
module rv_run_ctrl
    import rv_run_ctrl_pkg::*;
#(
    parameter int          AW         = 32,
    parameter logic [31:0] HALT_INSTR = HALT_OPCODE,
    parameter int unsigned MAX_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_start,
    input  logic          host_abort,
    input  logic          host_clear,
    input  logic          host_sel,
    input  logic          host_wr_en,
    input  logic          host_rd_en,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_wdata,
    output logic [31:0]   host_rdata,
    output logic          host_rvalid,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [31:0]   cycle_count,
    output logic          core_rst_n,
    input  logic [31:0]   core_imem_addr,
    output logic [31:0]   core_imem_rdata,
    input  logic [31:0]   core_dmem_addr,
    input  logic [31:0]   core_dmem_wdata,
    input  logic [3:0]    core_dmem_we,
    output logic [31:0]   core_dmem_rdata,
    output logic [31:0]   imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [3:0]    imem_we,
    output logic          imem_en,
    input  logic [31:0]   imem_rdata,
    output logic [31:0]   dmem_addr,
    output logic [31:0]   dmem_wdata,
    output logic [3:0]    dmem_we,
    output logic          dmem_en,
    input  logic [31:0]   dmem_rdata
);

    localparam bit          TO_EN   = (MAX_CYCLES != 0);
    localparam logic [31:0] TO_LAST = TO_EN ? 32'(MAX_CYCLES - 1) : 32'd0;

    run_state_t  state_q, state_d;
    logic        core_rst_n_q, core_rst_n_d;
    logic        timeout_q, timeout_d;
    logic [31:0] count_q, count_d;
    logic        rvalid_q, rvalid_d;
    logic        rsel_q, rsel_d;

    logic        halt_hit;
    logic        to_hit;
    logic        host_own;
    logic [31:0] host_addr32;

    assign host_addr32 = 32'(host_addr);
    assign host_own    = (state_q != S_RUN);
    assign halt_hit    = core_rst_n_q && (imem_rdata == HALT_INSTR);
    assign to_hit      = TO_EN && (count_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        count_d   = count_q;
        case (state_q)
            S_IDLE: begin
                if (host_start) begin
                    state_d   = S_RUN;
                    count_d   = 32'd0;
                    timeout_d = 1'b0;
                end
            end
            S_RUN: begin
                if (count_q != 32'hFFFF_FFFF) begin
                    count_d = count_q + 32'd1;
                end
                // halt wins a same-cycle tie with the timeout limit
                if (halt_hit) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b0;
                end else if (to_hit) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            S_DONE: begin
                if (host_clear) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (host_abort) begin
            state_d   = S_IDLE;
            timeout_d = 1'b0;
            count_d   = count_q;
        end
        core_rst_n_d = (state_d == S_RUN);
        rvalid_d     = host_rd_en && host_own;
        rsel_d       = host_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            core_rst_n_q <= 1'b0;
            timeout_q    <= 1'b0;
            count_q      <= 32'd0;
            rvalid_q     <= 1'b0;
            rsel_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_rst_n_q <= core_rst_n_d;
            timeout_q    <= timeout_d;
            count_q      <= count_d;
            rvalid_q     <= rvalid_d;
            rsel_q       <= rsel_d;
        end
    end

    // BRAM port B mux: the core owns both memories only while running
    always_comb begin
        imem_en = 1'b1;
        dmem_en = 1'b1;
        if (host_own) begin
            imem_addr  = host_addr32;
            imem_wdata = host_wdata;
            imem_we    = {4{host_wr_en && !host_sel}};
            dmem_addr  = host_addr32;
            dmem_wdata = host_wdata;
            dmem_we    = {4{host_wr_en && host_sel}};
        end else begin
            imem_addr  = core_imem_addr;
            imem_wdata = 32'd0;
            imem_we    = 4'd0;
            dmem_addr  = core_dmem_addr;
            dmem_wdata = core_dmem_wdata;
            dmem_we    = core_dmem_we;
        end
    end

    assign core_imem_rdata = imem_rdata;
    assign core_dmem_rdata = dmem_rdata;
    assign host_rvalid     = rvalid_q;
    assign host_rdata      = rvalid_q ? (rsel_q ? dmem_rdata : imem_rdata) : 32'd0;
    assign busy            = (state_q == S_RUN);
    assign done            = (state_q == S_DONE);
    assign timeout         = timeout_q;
    assign cycle_count     = count_q;
    assign core_rst_n      = core_rst_n_q;

endmodule
